watch_timekeeper: RTL and testbench
===================================

# watch_timekeeper

Parametrised time-of-day counter for the watch chip, the successor to the fixed 1 Hz hours/minutes/seconds counter. It divides a fast input clock down to one-second ticks, keeps seconds/minutes/hours, and adds synchronous time-set with range checking, a 12/24-hour display mode and a day-rollover pulse. An optional hh:mm alarm can be compiled in. The block sits between the oscillator divider and the display/mode logic.

## Interface

Parameters:
- TICKS_PER_SEC, default 1: enabled clock cycles per second advance; legal range 1..2^20.
- PRE_W, default 20: prescaler width; must satisfy 2^PRE_W >= TICKS_PER_SEC.

Ports:
- Clk_1sec  input  1  block clock; a 1 Hz clock when TICKS_PER_SEC=1.
- reset  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
- clock_enable  input  1  1 = timekeeping runs; 0 = freezes prescaler and counters.
- mode_12h  input  1  0 = 24-hour display, 1 = 12-hour display.
- set_valid  input  1  one-cycle time-load request.
- set_sec, set_min, set_hour  input  6 each  load values in 24-hour encoding.
- set_err  output  1  one-cycle pulse when a load is rejected.
- seconds, minutes  output  6 each  0..59.
- hours  output  6  0..23 (24h mode) or 1..12 (12h mode).
- pm  output  1  1 when internal hour is 12..23, in either mode.
- day_tick  output  1  one-cycle pulse on rollover from 23:59:59.
- With WATCH_ALARM_EN only: alarm_set (in, 1), alarm_min (in, 6), alarm_hour (in, 6, 24h), alarm_arm (in, 1), alarm_clr (in, 1), alarm (out, 1).

## Operation

- Internal registers: prescaler pre (PRE_W bits), sec, min, hr24. All are 0 in reset.
- Outputs in reset: seconds, minutes and hours 0 (the 12h display is applied only after reset releases), pm 0, set_err 0, day_tick 0, alarm 0.
- Prescaler: when clock_enable=1, pre increments. At pre==TICKS_PER_SEC-1 it wraps to 0 and asserts an internal sec_tick for that cycle. When TICKS_PER_SEC=1, every enabled cycle is a sec_tick.
- Carry chain on sec_tick:
  - sec 59 -> 0 and increments min.
  - min 59 -> 0 and increments hr24.
  - hr24 23 -> 0 and asserts day_tick.
  - Counters never take values outside their range.
- Display: seconds and minutes are the registers directly. hours is combinational from hr24.
  - mode_12h=0: hours = hr24.
  - mode_12h=1: 0 -> 12, 1..12 -> unchanged, 13..23 -> hr24-12.
  - pm = (hr24 >= 12). Changing mode_12h affects hours in the same cycle and never alters state.
- Time load: on set_valid=1 the values are checked against sec<=59, min<=59, hour<=23.
  - All in range: at the next edge, sec/min/hr24 take the set values and pre clears to 0.
  - Any out of range: no state changes; set_err pulses high for the following cycle.
  - A load is accepted regardless of clock_enable.
- Priority: a load beats a sec_tick in the same cycle. The tick is discarded and day_tick is not asserted.
- Reset mid-operation: asynchronous assertion clears all state immediately, including any pending set_err, day_tick or alarm.

## Timing

- Registers update on the rising edge of Clk_1sec.
- The sec_tick update and day_tick appear together on the edge after the terminal-count cycle. day_tick is high for exactly one cycle.
- A load takes effect one cycle after set_valid. set_err has the same one-cycle latency.
- After reset release with clock_enable=1, the first second advance occurs at the end of the TICKS_PER_SEC-th enabled cycle.
- Deasserting clock_enable holds pre. Re-enabling resumes from the held count; it does not restart.

## Configuration

- WATCH_ALARM_EN defined:
  - alarm_set stores alarm_min/alarm_hour. Out-of-range values are ignored: no store, and no set_err.
  - alarm latches 1 on the edge where a sec_tick or accepted load makes the time hr24:min:00 equal the stored alarm time while alarm_arm=1.
  - alarm stays 1 until alarm_clr. If a set event and alarm_clr coincide, the set wins.
- WATCH_ALARM_EN undefined: the alarm ports and logic are absent. The rest of the behaviour is identical.

## Test plan

- TICKS_PER_SEC=4: release reset with clock_enable=1 -> seconds=1 after 4 cycles and 2 after 8; clock_enable=0 for 10 cycles -> no change.
- Load 23:59:59, then one second of ticks -> 00:00:00, day_tick high exactly one cycle, pm 1->0.
- set_valid with set_min=60 -> set_err pulses one cycle, time unchanged. A load coincident with a sec_tick -> loaded values exact, no increment.
- mode_12h=1 with hr24 at 0, 12 and 13 -> hours 12/pm 0, 12/pm 1, 1/pm 1. Toggling the mode never changes the seconds count.
- Assert reset mid-count at 10:20:30 -> all outputs 0 immediately. After release the first advance occurs after a full TICKS_PER_SEC.
- WATCH_ALARM_EN: alarm 07:00 armed, load 06:59:59, tick -> alarm=1 at 07:00:00; alarm_clr -> 0; with arm=0 -> alarm stays 0.

Source files
------------

// File: rtl/watch_timekeeper.sv
// watch_timekeeper: prescaled hh:mm:ss time-of-day counter with range-checked load,
// 12/24h display and day-rollover pulse; define WATCH_ALARM_EN to add the hh:mm alarm.
module watch_timekeeper #(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRE_W = 20
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic       clock_enable,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [5:0] set_sec,
  input  logic [5:0] set_min,
  input  logic [5:0] set_hour,
`ifdef WATCH_ALARM_EN
  input  logic       alarm_set,
  input  logic [5:0] alarm_min,
  input  logic [5:0] alarm_hour,
  input  logic       alarm_arm,
  input  logic       alarm_clr,
  output logic       alarm,
`endif
  output logic       set_err,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic       pm,
  output logic       day_tick
);
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(TICKS_PER_SEC - 1);
  logic [PRE_W-1:0] pre, pre_n;
  logic [5:0] sec, min, hr24, sec_n, min_n, hr_n;
  logic sec_tick, set_ok, sec_wrap, min_wrap, rollover;
  always_comb begin
    sec_tick = clock_enable && pre == PRE_TC;
    set_ok = set_valid && set_sec <= 6'd59 && set_min <= 6'd59 && set_hour <= 6'd23;
    sec_wrap = sec == 6'd59;
    min_wrap = sec_wrap && min == 6'd59;
    rollover = min_wrap && hr24 == 6'd23;
    pre_n = (set_ok || sec_tick) ? '0 : clock_enable ? pre + PRE_W'(1) : pre;
    sec_n = set_ok ? set_sec : !sec_tick ? sec : sec_wrap ? 6'd0 : sec + 6'd1;
    min_n = set_ok ? set_min : !(sec_tick && sec_wrap) ? min : min == 6'd59 ? 6'd0 : min + 6'd1;
    hr_n = set_ok ? set_hour : !(sec_tick && min_wrap) ? hr24 : hr24 == 6'd23 ? 6'd0 : hr24 + 6'd1;
  end
  always_ff @(posedge Clk_1sec or negedge reset)
    if (!reset) begin
      pre <= '0;
      sec <= '0;
      min <= '0;
      hr24 <= '0;
      set_err <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      pre <= pre_n;
      sec <= sec_n;
      min <= min_n;
      hr24 <= hr_n;
      set_err <= set_valid && !set_ok;
      day_tick <= sec_tick && !set_ok && rollover;
    end
  // 12h view is suppressed while reset is held so all outputs read zero
  assign seconds = sec;
  assign minutes = min;
  assign pm = hr24 >= 6'd12;
  assign hours = !reset ? 6'd0 : !mode_12h ? hr24 : hr24 == 6'd0 ? 6'd12 : hr24 > 6'd12 ? hr24 - 6'd12 : hr24;
`ifdef WATCH_ALARM_EN
  logic [5:0] al_min, al_hr;
  logic al_hit;
  assign al_hit = alarm_arm && (set_ok || sec_tick) && sec_n == 6'd0 && min_n == al_min && hr_n == al_hr;
  always_ff @(posedge Clk_1sec or negedge reset)
    if (!reset) begin
      al_min <= '0;
      al_hr <= '0;
      alarm <= 1'b0;
    end else begin
      if (alarm_set && alarm_min <= 6'd59 && alarm_hour <= 6'd23) begin
        al_min <= alarm_min;
        al_hr <= alarm_hour;
      end
      alarm <= al_hit ? 1'b1 : alarm_clr ? 1'b0 : alarm;
    end
`endif
endmodule

// File: tb/tb_watch_timekeeper.sv
// tb_watch_timekeeper: random and directed checks of watch_timekeeper (TICKS_PER_SEC=4)
// against a seconds-since-midnight reference model.
module tb_watch_timekeeper;
  localparam int TPS = 4;
  logic clk = 0, rst_n = 0, ce = 0, mode = 0, sv = 0;
  logic [5:0] ss = 0, sm = 0, sh = 0;
  logic set_err, pm, day_tick;
  logic [5:0] seconds, minutes, hours;
`ifdef WATCH_ALARM_EN
  logic a_set = 0, a_arm = 0, a_clr = 0, alarm;
  logic [5:0] a_min = 0, a_hr = 0;
`endif
  int n_cmp = 0, n_bad = 0;
  int m_t = 0, m_pre = 0;
  bit m_err = 0, m_day = 0, m_ok = 0;
  int hv[3] = '{0, 12, 13};
  int he[3] = '{12, 12, 1};
  int pe[3] = '{0, 1, 1};
  int k, sec_hold;

  always #5 clk = ~clk;

  watch_timekeeper #(.TICKS_PER_SEC(TPS), .PRE_W(3)) dut (
    .Clk_1sec(clk), .reset(rst_n), .clock_enable(ce), .mode_12h(mode),
    .set_valid(sv), .set_sec(ss), .set_min(sm), .set_hour(sh),
`ifdef WATCH_ALARM_EN
    .alarm_set(a_set), .alarm_min(a_min), .alarm_hour(a_hr),
    .alarm_arm(a_arm), .alarm_clr(a_clr), .alarm(alarm),
`endif
    .set_err(set_err), .seconds(seconds), .minutes(minutes), .hours(hours),
    .pm(pm), .day_tick(day_tick)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int h, input int m, input int s);
    sv = 1; sh = 6'(h); sm = 6'(m); ss = 6'(s);
    step(1);
    sv = 0;
  endtask

  function automatic int disp_h(input int h, input bit m12);
    return m12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
  endfunction

  // reference: time as seconds since midnight, prescaler as a modulo count
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_t = 0; m_pre = 0; m_err = 0; m_day = 0;
    end else begin
      m_ok = sv && ss < 60 && sm < 60 && sh < 24;
      m_err = sv && !m_ok;
      m_day = 0;
      if (m_ok) begin
        m_t = int'(sh) * 3600 + int'(sm) * 60 + int'(ss);
        m_pre = 0;
      end else if (ce) begin
        m_pre = (m_pre + 1) % TPS;
        if (m_pre == 0) begin
          m_day = (m_t == 86399);
          m_t = (m_t + 1) % 86400;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("seconds", int'(seconds), m_t % 60);
      chk("minutes", int'(minutes), (m_t / 60) % 60);
      chk("hours", int'(hours), disp_h(m_t / 3600, mode));
      chk("pm", int'(pm), int'(m_t >= 43200));
      chk("set_err", int'(set_err), int'(m_err));
      chk("day_tick", int'(day_tick), int'(m_day));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    mode = 1;
    #12;
    chk("rst_seconds", int'(seconds), 0);
    chk("rst_hours_12h", int'(hours), 0);
    chk("rst_pm", int'(pm), 0);
    chk("rst_set_err", int'(set_err), 0);
    chk("rst_day_tick", int'(day_tick), 0);
    mode = 0; ce = 1;
    @(posedge clk); #1;
    rst_n = 1;
    step(3); chk("adv_early", int'(seconds), 0);
    step(1); chk("adv_first", int'(seconds), 1);
    step(4); chk("adv_second", int'(seconds), 2);
    ce = 0;
    step(10); chk("frozen", int'(seconds), 2);
    load(23, 59, 59);
    chk("ld_hours", int'(hours), 23);
    chk("ld_pm", int'(pm), 1);
    ce = 1;
    step(3); chk("pre_roll_sec", int'(seconds), 59);
    chk("pre_roll_day", int'(day_tick), 0);
    step(1);
    chk("roll_sec", int'(seconds), 0);
    chk("roll_min", int'(minutes), 0);
    chk("roll_hours", int'(hours), 0);
    chk("roll_pm", int'(pm), 0);
    chk("roll_day", int'(day_tick), 1);
    step(1); chk("roll_day_off", int'(day_tick), 0);
    ce = 0;
    load(5, 60, 5);
    chk("bad_err", int'(set_err), 1);
    chk("bad_min", int'(minutes), 0);
    chk("bad_hours", int'(hours), 0);
    step(1); chk("bad_err_off", int'(set_err), 0);
    load(1, 2, 3);
    ce = 1;
    step(3); chk("coin_pre_sec", int'(seconds), 3);
    load(10, 20, 30);
    chk("coin_sec", int'(seconds), 30);
    chk("coin_min", int'(minutes), 20);
    chk("coin_hours", int'(hours), 10);
    step(3); chk("mid_sec", int'(seconds), 30);
    rst_n = 0; #1;
    chk("async_sec", int'(seconds), 0);
    chk("async_min", int'(minutes), 0);
    chk("async_hours", int'(hours), 0);
    step(2);
    rst_n = 1;
    step(3); chk("rel_early", int'(seconds), 0);
    step(1); chk("rel_first", int'(seconds), 1);
    ce = 0;
    for (int i = 0; i < 3; i++) begin
      load(hv[i], 7, 42);
      mode = 1; #1;
      chk("h12_hours", int'(hours), he[i]);
      chk("h12_pm", int'(pm), pe[i]);
      mode = 0; #1;
      chk("h24_hours", int'(hours), hv[i]);
      chk("mode_sec", int'(seconds), 42);
    end
    ce = 1; mode = 1;
    step(2); sec_hold = int'(seconds);
    mode = 0; #1;
    chk("toggle_sec", int'(seconds), sec_hold);
`ifdef WATCH_ALARM_EN
    ce = 0;
    a_min = 0; a_hr = 7; a_set = 1;
    step(1);
    a_set = 0; a_arm = 1;
    load(6, 59, 59);
    chk("alarm_idle", int'(alarm), 0);
    ce = 1;
    step(4); chk("alarm_fire", int'(alarm), 1);
    ce = 0; a_clr = 1;
    step(1); a_clr = 0;
    chk("alarm_clr", int'(alarm), 0);
    a_arm = 0;
    load(6, 59, 59);
    ce = 1;
    step(4); chk("alarm_disarmed", int'(alarm), 0);
`endif
    repeat (3000) begin
      ce = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 1) != 0);
      sv = 0;
      if ($urandom_range(0, 15) == 0) begin
        sv = 1;
        k = int'($urandom_range(0, 2));
        if (!ce && $urandom_range(0, 2) == 0) begin
          ss = 6'(k == 0 ? $urandom_range(60, 63) : $urandom_range(0, 59));
          sm = 6'(k == 1 ? $urandom_range(60, 63) : $urandom_range(0, 59));
          sh = 6'(k == 2 ? $urandom_range(24, 63) : $urandom_range(0, 23));
        end else if (k == 0) begin
          sh = 23; sm = 59; ss = 6'($urandom_range(50, 59));
        end else begin
          sh = 6'($urandom_range(0, 23));
          sm = 6'($urandom_range(0, 59));
          ss = 6'($urandom_range(0, 59));
        end
      end
      step(1);
    end
    sv = 0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
